// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one upstream valid/ready port, N_CH downstream
// valid/ready channels, and the out-of-range select error outputs.
interface demux_stream_if #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 1
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_bcast;
  logic [N_CH-1:0]          out_valid;
  logic [N_CH-1:0]          out_ready;
  logic [N_CH*DATA_W-1:0]   out_data;
  logic                     err_sel;
  logic [7:0]               err_cnt;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err_sel, err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err_sel, err_cnt
  );
endinterface

// File: rtl/demux_stream.sv
// 1:N_CH stream demultiplexer with a one-entry register per output channel,
// broadcast mode, and detection/counting of out-of-range selects.
module demux_stream #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 1
) (
  input logic           clk,
  input logic           rst,
  demux_stream_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]        valid_q, valid_d;
  logic [N_CH*DATA_W-1:0] data_q, data_d;
  logic [N_CH-1:0]        can_load, sel_hit, load;
  logic                   sel_ok, accept, drop;
  logic                   err_q;
  logic [7:0]             cnt_q, cnt_d;

  // Decoding by equality keeps the range check valid for any N_CH, pow2 or not.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_hit[k] = (bus.in_sel == SEL_W'(k));
    end
  end

  assign can_load = ~valid_q | bus.out_ready;
  assign sel_ok   = |sel_hit;

  assign bus.in_ready = bus.in_bcast ? (&can_load)
                      : sel_ok       ? (|(sel_hit & can_load))
                      :                1'b1;

  assign accept = bus.in_valid & bus.in_ready;
  assign drop   = accept & ~bus.in_bcast & ~sel_ok;

  always_comb begin
    load = '0;
    if (accept) begin
      load = bus.in_bcast ? {N_CH{1'b1}} : sel_hit;
    end
  end

  // A draining channel may reload in the same cycle, so load wins over drain.
  always_comb begin
    valid_d = load | (valid_q & ~bus.out_ready);
    data_d  = data_q;
    for (int k = 0; k < N_CH; k++) begin
      if (load[k]) begin
        data_d[k*DATA_W +: DATA_W] = bus.in_data;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (drop && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= drop;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.err_sel   = err_q;
  assign bus.err_cnt   = cnt_q;
endmodule
